axi_read_data_responder: RTL and testbench

//  Slave-side AXI read data channel: transmits one read burst on RID/RDATA/RRESP/RLAST/RVALID

---
 rtl/axi_read_data_responder.sv | 104 ++++++++++
 tb/tb_axi_read_data_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_data_responder.sv
// AXI slave read-data channel: streams one burst from a local source FIFO through a registered R stage.
// Optional macro AXI_RD_SLVERR_EN adds the slverr port and answers the whole burst with SLVERR.
module axi_read_data_responder #(
  parameter int data_width = 32,
  parameter int id_width   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  go,
  input  logic [7:0]            burst_len,
  input  logic [id_width-1:0]   burst_id,
`ifdef AXI_RD_SLVERR_EN
  input  logic                  slverr,
`endif
  input  logic [data_width-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic                  busy,
  output logic                  done,
  output logic [id_width-1:0]   RID,
  output logic [data_width-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STREAM   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0] state;
  logic [7:0] len_q;
  logic [8:0] load_cnt;
  logic       err_sel;
  logic       load;
  logic       last_acc;

  function automatic logic [1:0] resp_code(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

`ifdef AXI_RD_SLVERR_EN
  assign err_sel = slverr;
`else
  assign err_sel = 1'b0;
`endif

  // The output register may be refilled whenever it is empty or being drained this cycle.
  assign load      = (state == STREAM) && src_valid && (load_cnt <= {1'b0, len_q})
                     && (!RVALID || RREADY);
  assign last_acc  = RVALID && RREADY && RLAST;
  assign src_ready = load;
  assign busy      = (state == STREAM);
  assign done      = (state == COMPLETE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      len_q    <= 8'd0;
      load_cnt <= 9'd0;
      RID      <= '0;
      RRESP    <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state    <= STREAM;
            len_q    <= burst_len;
            RID      <= burst_id;
            RRESP    <= resp_code(err_sel);
            load_cnt <= 9'd0;
          end
        end
        STREAM: begin
          if (load) load_cnt <= load_cnt + 9'd1;
          if (last_acc) state <= COMPLETE;
        end
        COMPLETE: begin
          if (!go) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered R stage: outputs hold while RVALID && !RREADY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      RDATA  <= '0;
      RVALID <= 1'b0;
      RLAST  <= 1'b0;
    end else if (load) begin
      RDATA  <= src_data;
      RVALID <= 1'b1;
      RLAST  <= (load_cnt == {1'b0, len_q});
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_read_data_responder.sv
// Self-checking bench for axi_read_data_responder: table-driven bursts, random bursts, reset mid-burst.
// Build with +define+AXI_RD_SLVERR_EN to also exercise the SLVERR response.
module tb_axi_read_data_responder;
  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic [7:0]  burst_len;
  logic [3:0]  burst_id;
`ifdef AXI_RD_SLVERR_EN
  logic        slverr;
`endif
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        busy;
  logic        done;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  axi_read_data_responder #(.data_width(32), .id_width(4)) dut (
    .clk(clk), .resetn(resetn), .go(go), .burst_len(burst_len), .burst_id(burst_id),
`ifdef AXI_RD_SLVERR_EN
    .slverr(slverr),
`endif
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .busy(busy), .done(done),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [3:0]  id;
    logic [31:0] base;     // 0 = random data
    int          gap;      // percent of cycles with src_valid forced low
    int          stall;    // percent of cycles with RREADY low
    int          hold;     // beat index that gets a 3-cycle RREADY stall, -1 = none
    logic        err;
    int          exp_beats;
    int          exp_lat;  // cycles from go to first RVALID, -1 = unchecked
    int          exp_cyc;  // cycles from go to done, -1 = unchecked
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] src_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_burst(input vec_t v);
    logic [31:0] exp_q[$];
    logic [31:0] s_data;
    logic        s_last;
    logic [3:0]  s_id;
    logic [1:0]  s_resp;
    logic [1:0]  exp_resp;
    int beats = 0, pops = 0, c = 0, first = -1, hold_left = 0;
    bit held = 0, pv_stall = 0;
    exp_resp = v.err ? 2'b10 : 2'b00;
    src_q.delete();
    for (int i = 0; i <= v.len; i++) src_q.push_back(v.base != 0 ? v.base + i : $urandom);
    exp_q = src_q;
    src_q.push_back(32'hDEAD0001);
    src_q.push_back(32'hDEAD0002);
    burst_len = v.len[7:0];
    burst_id  = v.id;
`ifdef AXI_RD_SLVERR_EN
    slverr = v.err;
`endif
    go = 1'b1;
    forever begin
      if (c > 0 && done) break;
      if (c > 20 * (v.len + 1) + 40) begin
        chk("timeout", 0, 1);
        break;
      end
      if (c == 1) chk("busy_stream", busy, 1);
      if (RVALID && first < 0) first = c;
      if (pv_stall)
        chk("hold_stable", {RVALID, RDATA, RLAST, RID, RRESP}, {1'b1, s_data, s_last, s_id, s_resp});
      if (RVALID && beats == v.hold && !held) begin
        held = 1;
        hold_left = 3;
      end
      RREADY = (hold_left > 0) ? 1'b0 : ($urandom_range(99) >= v.stall);
      if (hold_left > 0) hold_left--;
      src_valid = (src_q.size() > 0) && ($urandom_range(99) >= v.gap);
      src_data  = src_valid ? src_q[0] : $urandom;
      #1;
      if (RVALID && RREADY) begin
        if (beats <= v.len)
          chk("beat", {RDATA, RLAST, RID, RRESP}, {exp_q[beats], (beats == v.len), v.id, exp_resp});
        else
          chk("extra_beat", 1, 0);
        beats++;
      end
      pv_stall = RVALID && !RREADY;
      s_data = RDATA; s_last = RLAST; s_id = RID; s_resp = RRESP;
      if (src_ready) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        pops++;
      end
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    chk("beat_count", beats, v.exp_beats);
    chk("pop_count", pops, v.exp_beats);
    chk("fifo_left", src_q.size(), 2);
    if (v.exp_lat >= 0) chk("first_lat", first, v.exp_lat);
    if (v.exp_cyc >= 0) chk("burst_cycles", c, v.exp_cyc);
    // go still high in COMPLETE: done holds, nothing restarts
    for (int k = 0; k < 2; k++) begin
      RREADY = 1'b1;
      src_valid = 1'b1;
      src_data = src_q[0];
      #1;
      chk("complete_hold", {done, busy, RVALID, src_ready}, {1'b1, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      @(negedge clk);
    end
    go = 1'b0;
    src_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("back_idle", {done, busy}, 2'b00);
  endtask

  function automatic vec_t mk(input int len, input logic [3:0] id, input logic [31:0] base,
                              input int gap, input int stall, input int hold, input logic err);
    vec_t v;
    v.len = len; v.id = id; v.base = base; v.gap = gap; v.stall = stall; v.hold = hold; v.err = err;
    v.exp_beats = len + 1;
    v.exp_lat   = (gap == 0 && stall == 0) ? 2 : -1;
    v.exp_cyc   = (gap == 0 && stall == 0 && hold < 0) ? len + 3 : -1;
    return v;
  endfunction

  initial begin
    resetn = 1'b0; go = 1'b0; burst_len = 8'd0; burst_id = 4'd0;
    src_data = 32'd0; src_valid = 1'b0; RREADY = 1'b0;
`ifdef AXI_RD_SLVERR_EN
    slverr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_regs", {RLAST, RID, RDATA, RRESP}, 0);
    chk("rst_ctrl", {done, busy, src_ready}, 0);
    resetn = 1'b1;
    @(negedge clk);

    vecs.push_back(mk(0,   4'h5, 32'hA5A5A5A5, 0,  0,  -1, 1'b0));
    vecs.push_back(mk(3,   4'h3, 32'h00000001, 0,  0,  1,  1'b0));
    vecs.push_back(mk(255, 4'hA, 32'h00001000, 0,  0,  -1, 1'b0));
    vecs.push_back(mk(7,   4'h6, 32'h00002000, 40, 0,  -1, 1'b0));
    vecs.push_back(mk(15,  4'hC, 32'd0,        30, 30, 4,  1'b0));
    for (int i = 0; i < 6; i++) begin
      int l = $urandom_range(0, 40);
      vecs.push_back(mk(l, 4'($urandom), 32'd0, $urandom_range(0, 50), $urandom_range(0, 50),
                        ($urandom_range(1) == 1) ? $urandom_range(0, l) : -1, 1'b0));
    end
`ifdef AXI_RD_SLVERR_EN
    vecs.push_back(mk(1, 4'h2, 32'h00003000, 0, 0, -1, 1'b1));
    vecs.push_back(mk(1, 4'h2, 32'h00004000, 0, 0, -1, 1'b0));
`endif
    foreach (vecs[i]) run_burst(vecs[i]);

    // reset asserted while beat 2 of 4 is on the bus
    go = 1'b1; burst_len = 8'd3; burst_id = 4'h9; RREADY = 1'b1;
    src_valid = 1'b1; src_data = 32'h100;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    src_data = 32'h101;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_beat", {RVALID, RDATA}, {1'b1, 32'h101});
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_rvalid", RVALID, 0);
    chk("rst_mid_state", {busy, done, src_ready, RDATA}, 0);
    go = 1'b0; src_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_idle", {busy, RVALID}, 0);
    run_burst(mk(3, 4'h7, 32'h00005000, 0, 0, -1, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
